// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch prefetch unit.
package fetch_pkg;

  localparam int unsigned FETCH_PC_SIZE  = 16;
  localparam int unsigned FETCH_INSTR_W  = 16;
  localparam int unsigned FETCH_OFFSET_W = 16;

  // One prefetched instruction together with the address it was fetched from.
  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_PC_SIZE-1:0] pc;
  } fetch_entry_t;

  // Sign-extend a redirect offset to PC width (default widths).
  function automatic logic [FETCH_PC_SIZE-1:0] sext_offset(input logic [FETCH_OFFSET_W-1:0] off);
    return FETCH_PC_SIZE'($signed(off));
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO with wrap-bit pointers and a single-cycle flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             flush,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t           mem [DEPTH];
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  // Pointer update; flush wins over push/pop so a redirect empties the queue.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CNT_W'(1);
      if (pop)  rd_ptr <= rd_ptr + CNT_W'(1);
    end
  end

  // Entry storage; cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Sequential fetch-address generator with credit-limited requests, in-order
// response tracking, stale-response discard and a prefetch queue to the decoder.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       PC_SIZE  = FETCH_PC_SIZE,
  parameter int unsigned       INSTR_W  = FETCH_INSTR_W,
  parameter int unsigned       OFFSET_W = FETCH_OFFSET_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                redirect_valid,
  input  logic [PC_SIZE-1:0]  redirect_pc,
  input  logic [OFFSET_W-1:0] redirect_offset,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [PC_SIZE-1:0]  imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [INSTR_W-1:0]  imem_rsp_data,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr_data,
  output logic [PC_SIZE-1:0]  instr_pc
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  // Stale responses can pile up across back-to-back redirects, so give headroom.
  localparam int unsigned DISC_W = CNT_W + 3;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_SIZE-1:0] pc;
  } entry_t;

  logic               active;
  logic [PC_SIZE-1:0] fetch_pc;
  logic [PC_SIZE-1:0] tail_pc;
  logic [PC_SIZE-1:0] target_pc;
  logic [CNT_W-1:0]   outstanding;
  logic [DISC_W-1:0]  discard;
  logic [CNT_W-1:0]   q_count;
  logic [CNT_W:0]     inflight;
  logic               q_full;
  logic               q_empty;
  logic               q_push;
  logic               q_pop;
  logic               req_fire;
  logic               rsp_take;
  logic               rsp_drop;
  entry_t             q_head;
  entry_t             q_push_data;

  assign target_pc = redirect_pc + PC_SIZE'($signed(redirect_offset));
  assign inflight  = (CNT_W+1)'(q_count) + (CNT_W+1)'(outstanding);

  assign imem_req_valid = active & ~redirect_valid & (inflight < (CNT_W+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_drop = imem_rsp_valid & (discard != '0);
  assign rsp_take = imem_rsp_valid & (discard == '0);

  assign q_push      = rsp_take & ~redirect_valid;
  assign q_push_data = '{instr: imem_rsp_data, pc: tail_pc};

  assign instr_valid = ~q_empty & ~redirect_valid;
  assign q_pop       = instr_valid & instr_ready;
  assign instr_data  = q_head.instr;
  assign instr_pc    = q_head.pc;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Fetch PC, tail PC and request/discard bookkeeping; redirect moves live requests to discard.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      active      <= 1'b0;
      fetch_pc    <= RESET_PC;
      tail_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      active <= 1'b1;
      if (redirect_valid) begin
        fetch_pc    <= target_pc;
        tail_pc     <= target_pc;
        outstanding <= '0;
        discard     <= discard + DISC_W'(outstanding) - DISC_W'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_SIZE'(1);
        if (rsp_take) tail_pc  <= tail_pc + PC_SIZE'(1);
        outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_take);
        discard     <= discard - DISC_W'(rsp_drop);
      end
    end
  end

  // Credits keep count + outstanding within DEPTH, so a push never meets a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (!n_rst)
    !(q_push && q_full && !q_pop));

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Parametrised successor to the single-cycle PC counter.
- Generates sequential instruction-fetch addresses and issues them over a valid/ready request channel to instruction memory.
- Buffers in-order responses in a DEPTH-entry prefetch queue and hands {instruction, PC} to the decoder under valid/ready backpressure.
- Branch-controller redirects flush the queue and discard in-flight responses; sits between the branch controller, instruction memory and the decoder.

Parameters:
- PC_SIZE, 16: width of PC and memory address.
- INSTR_W, 16: instruction word width.
- OFFSET_W, 16: width of the signed redirect offset (OFFSET_W <= PC_SIZE).
- DEPTH, 4: prefetch queue entries and maximum outstanding requests; power of two, >= 2.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- redirect_valid  in  1  branch controller overrides the PC this cycle.
- redirect_pc  in  PC_SIZE  PC of the redirecting branch.
- redirect_offset  in  OFFSET_W  two's-complement offset relative to redirect_pc.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  PC_SIZE  fetch address.
- imem_rsp_valid  in  1  response valid; responses return in request order; no backpressure.
- imem_rsp_data  in  INSTR_W  fetched instruction.
- instr_valid  out  1  queue head valid to decoder.
- instr_ready  in  1  decoder consumes head.
- instr_data  out  INSTR_W  head instruction.
- instr_pc  out  PC_SIZE  address of head instruction.

Behaviour:
- Reset (async, n_rst low): fetch_pc = RESET_PC; queue empty; outstanding = 0; discard = 0. Outputs: imem_req_valid 0, instr_valid 0, imem_req_addr RESET_PC, instr_data 0, instr_pc 0.
  - If reset asserts mid-operation, all in-flight responses are forgotten. Memory must also be reset.
- Credits: imem_req_valid = (count + outstanding < DEPTH) & ~redirect_valid. A request is never issued in a redirect cycle.
- imem_req_addr = fetch_pc (registered).
- On a request handshake: fetch_pc <= fetch_pc + 1, wrapping modulo 2^PC_SIZE; outstanding++.
- On imem_rsp_valid:
  - If discard > 0: decrement discard and drop the data.
  - Else: decrement outstanding and push {data, pc of that request} into the queue. Tail PC comes from a tail-pc register advanced per push.
- Same-cycle handshake and response: outstanding unchanged.
- Queue output is registered: a response becomes visible on instr_valid no earlier than the next cycle (min rsp-to-instr latency 1).
- instr_valid = ~empty & ~redirect_valid.
- Pop on instr_valid & instr_ready. Simultaneous push and pop is legal at any occupancy; credits guarantee no overflow. A push to a full queue is an assertion error.
- Redirect (redirect_valid=1 at edge N):
  - target = redirect_pc + sign_extend(redirect_offset) mod 2^PC_SIZE.
  - fetch_pc <= target; tail pc <= target; queue emptied.
  - discard <= discard + outstanding - (1 if a response is dropped or consumed this cycle); outstanding <= 0.
  - Cycle N+1: imem_req_valid=1 with imem_req_addr=target.
  - Consecutive redirects: the last one wins; discard accumulates.
- Empty queue with instr_ready high: no pop, instr_valid 0. Fully backpressured decoder: requests stall once count + outstanding = DEPTH.

Decomposition:
- Shared package (fetch_pkg):
  - PC_SIZE / INSTR_W defaults.
  - typedef fetch_entry_t {instr, pc}.
  - function sext_offset.
- One sub-module: fetch_queue. Parametrised circular FIFO over fetch_entry_t with push, pop, flush, count, full and empty, using wrap-around pointers of log2(DEPTH)+1 bits.
- Top holds fetch_pc, tail pc, outstanding/discard counters and the redirect adder.

Test Plan:
- Reset release, memory always ready, 1-cycle response, decoder always ready -> requests at addresses 0,1,2,…, one per cycle. instr_pc follows 0,1,2 with matching data; first instr_valid 2 cycles after the first request.
- instr_ready held low, DEPTH=4 -> exactly 4 requests issued (0–3), then imem_req_valid low. Release instr_ready -> PCs 0,1,2,3 popped in order, then fetch resumes at 4.
- Redirect with redirect_pc=0x0010, offset=0xFFF0 (-16), while 2 requests are outstanding -> queue flushed; next req_addr=0x0000. The 2 stale responses are dropped; first delivered instr_pc=0x0000.
- PC wrap: RESET_PC=0xFFFE -> request addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Redirect on consecutive cycles to 0x0100 then 0x0200 -> no request to 0x0100. First request and first instr_pc are 0x0200.
- n_rst pulsed low mid-stream with a full queue -> all outputs at reset values immediately (asynchronous). After release, fetch restarts at RESET_PC.
